// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard-control definitions: mul/div FSM encoding
// and default unit latencies used by the mul/div datapath.
package hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam int CNT_W_DEF   = 6;

endpackage

// File: rtl/hazard_ctrl_md_latency_tracker.sv
// Tracks occupancy of the multi-cycle HI/LO unit:
// busy for LAT-1 cycles after launch, done on the last one.
module md_latency_tracker
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state <= BUSY;
            cnt   <= is_div ? DIV_INIT : MUL_INIT;
          end
        end
        BUSY: begin
          cnt <= cnt - LAST;
          if (cnt == LAST) state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == BUSY);
  assign done = busy && (cnt == LAST);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush control for hazards the bypass network cannot
// resolve: load-use, busy HI/LO unit and taken-branch squash.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rf_raddr0_ID,
  input  logic [4:0]  rf_raddr1_ID,
  input  logic        rs_used_ID,
  input  logic        rt_used_ID,
  input  logic        rf_wen_EX,
  input  logic [4:0]  rf_waddr_EX,
  input  logic        mem_read_EX,
  input  logic        md_start_ID,
  input  logic        md_is_div_ID,
  input  logic        hilo_access_ID,
  input  logic        branch_taken_EX,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        bubble_EX,
  output logic        flush_ID,
  output logic        md_go,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  logic rs_hit;
  logic rt_hit;
  logic lu;
  logic mdh;
  logic stall;

  assign rs_hit = rs_used_ID && (rf_raddr0_ID == rf_waddr_EX);
  assign rt_hit = rt_used_ID && (rf_raddr1_ID == rf_waddr_EX);

  // r0 writes are discarded, so they never create a dependency
  assign lu = mem_read_EX && rf_wen_EX &&
              (rf_waddr_EX != 5'd0) && (rs_hit || rt_hit);

  assign mdh   = md_busy && (md_start_ID || hilo_access_ID);
  assign stall = (lu || mdh) && !branch_taken_EX;

  assign stall_IF  = stall;
  assign stall_ID  = stall;
  assign bubble_EX = stall;
  assign flush_ID  = branch_taken_EX;

  assign md_go = md_start_ID && !md_busy &&
                 !lu && !branch_taken_EX;

  md_latency_tracker #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md_trk (
    .clk    (clk),
    .rst    (rst),
    .go     (md_go),
    .is_div (md_is_div_ID),
    .busy   (md_busy),
    .done   (md_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: constant vector table, directed
// multi-cycle sequences and random traffic vs a cycle model.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  typedef struct packed {
    logic [4:0] ra0;
    logic [4:0] ra1;
    logic       rs_used;
    logic       rt_used;
    logic       wen;
    logic [4:0] waddr;
    logic       mrd;
    logic       start;
    logic       is_div;
    logic       hilo;
    logic       br;
  } in_t;

  typedef struct {
    in_t  in;
    logic stall;
    logic flush;
    logic go;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  in_t         cur = '0;
  logic        stall_IF, stall_ID, bubble_EX, flush_ID;
  logic        md_go, md_busy, md_done;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  int          rem = 0;
  logic [31:0] scnt = '0;
  logic        m_go, m_stall;
  logic        s_go, s_stall, s_busy, s_done, s_flush;

  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rf_raddr0_ID    (cur.ra0),
    .rf_raddr1_ID    (cur.ra1),
    .rs_used_ID      (cur.rs_used),
    .rt_used_ID      (cur.rt_used),
    .rf_wen_EX       (cur.wen),
    .rf_waddr_EX     (cur.waddr),
    .mem_read_EX     (cur.mrd),
    .md_start_ID     (cur.start),
    .md_is_div_ID    (cur.is_div),
    .hilo_access_ID  (cur.hilo),
    .branch_taken_EX (cur.br),
    .stall_IF        (stall_IF),
    .stall_ID        (stall_ID),
    .bubble_EX       (bubble_EX),
    .flush_ID        (flush_ID),
    .md_go           (md_go),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_cnt       (stall_cnt)
  );

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, got, exp, $time);
    end
  endtask

  function automatic in_t lw_use(logic [4:0] dst,
                                 logic [4:0] src);
    in_t v;
    v = '0;
    v.mrd = 1'b1;
    v.wen = 1'b1;
    v.waddr = dst;
    v.rs_used = 1'b1;
    v.ra0 = src;
    return v;
  endfunction

  function automatic in_t md_op(logic dv);
    in_t v;
    v = '0;
    v.start = 1'b1;
    v.is_div = dv;
    return v;
  endfunction

  // One clock: check every output against the model at the
  // negedge, then advance the model across the posedge.
  task automatic step();
    logic lu, busy, done, mdh;
    @(negedge clk);
    lu = cur.mrd && cur.wen && (cur.waddr != 0) &&
         ((cur.rs_used && cur.ra0 == cur.waddr) ||
          (cur.rt_used && cur.ra1 == cur.waddr));
    busy = (rem > 0);
    done = (rem == 1);
    mdh = busy && (cur.start || cur.hilo);
    m_stall = (lu || mdh) && !cur.br;
    m_go = cur.start && !busy && !lu && !cur.br;
    s_go = md_go;
    s_stall = stall_ID;
    s_busy = md_busy;
    s_done = md_done;
    s_flush = flush_ID;
    chk("stall_IF", stall_IF, m_stall);
    chk("stall_ID", stall_ID, m_stall);
    chk("bubble_EX", bubble_EX, m_stall);
    chk("flush_ID", flush_ID, cur.br);
    chk("md_go", md_go, m_go);
    chk("md_busy", md_busy, busy);
    chk("md_done", md_done, done);
    chk("stall_cnt", stall_cnt, scnt);
    @(posedge clk);
    if (rst) begin
      rem = 0;
      scnt = '0;
    end else begin
      if (rem > 0) rem--;
      else if (m_go) rem = (cur.is_div ? DIV_LAT : MUL_LAT) - 1;
      if (m_stall && scnt != 32'hFFFF_FFFF) scnt++;
    end
    #1;
  endtask

  task automatic add(in_t v, logic s, logic f, logic g);
    vec_t e;
    e.in = v;
    e.stall = s;
    e.flush = f;
    e.go = g;
    tbl.push_back(e);
  endtask

  initial begin
    in_t v;
    int busy_n, done_n, held, rel;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("reset_cnt", stall_cnt, 32'd0);

    // idle-state combinational vectors
    add(lw_use(5'd5, 5'd5), 1, 0, 0);
    v = '0; v.mrd = 1; v.wen = 1; v.waddr = 7;
    v.rt_used = 1; v.ra1 = 7;
    add(v, 1, 0, 0);
    add(lw_use(5'd0, 5'd0), 0, 0, 0);
    v = lw_use(5'd5, 5'd5); v.rs_used = 0;
    add(v, 0, 0, 0);
    v = lw_use(5'd5, 5'd5); v.mrd = 0;
    add(v, 0, 0, 0);
    v = lw_use(5'd5, 5'd5); v.wen = 0;
    add(v, 0, 0, 0);
    v = lw_use(5'd9, 5'd9); v.br = 1; v.start = 1;
    add(v, 0, 1, 0);
    add(md_op(1'b1), 0, 0, 1);
    v = lw_use(5'd3, 5'd3); v.start = 1;
    add(v, 1, 0, 0);
    v = '0; v.hilo = 1;
    add(v, 0, 0, 0);
    v = md_op(1'b0); v.br = 1;
    add(v, 0, 1, 0);
    v = lw_use(5'd6, 5'd5); v.ra1 = 6;
    add(v, 0, 0, 0);

    foreach (tbl[i]) begin
      cur = tbl[i].in;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), stall_ID, tbl[i].stall);
      chk($sformatf("vec%0d_bubble", i), bubble_EX, tbl[i].stall);
      chk($sformatf("vec%0d_flush", i), flush_ID, tbl[i].flush);
      chk($sformatf("vec%0d_go", i), md_go, tbl[i].go);
      @(posedge clk);
      #1;
      cur = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rem = 0;
      scnt = '0;
    end

    // load-use: one stall cycle, counter 0 -> 1
    cur = lw_use(5'd5, 5'd5);
    step();
    chk("lu_stall", s_stall, 1'b1);
    cur = '0;
    step();
    chk("lu_once", s_stall, 1'b0);
    chk("lu_cnt", stall_cnt, 32'd1);

    // divide with MFLO waiting behind it
    cur = md_op(1'b1);
    step();
    chk("div_go", s_go, 1'b1);
    cur = '0; cur.hilo = 1;
    busy_n = 0; done_n = 0; rel = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      busy_n += int'(s_busy);
      done_n += int'(s_done);
      if (!s_stall) begin
        rel = 1;
        chk("div_rel_busy", s_busy, 1'b0);
        break;
      end
    end
    chk("div_released", rel, 1);
    chk("div_busy_cycles", busy_n, DIV_LAT - 1);
    chk("div_done_pulses", done_n, 1);
    cur = '0;
    step();

    // back-to-back multiplies
    cur = md_op(1'b0);
    step();
    chk("mul1_go", s_go, 1'b1);
    held = 0; rel = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_go) begin
        rel = 1;
        chk("mul2_go_idle", s_busy, 1'b0);
        break;
      end
      held += int'(s_stall);
    end
    chk("mul2_launched", rel, 1);
    chk("mul2_held", held, MUL_LAT - 1);
    cur = '0;
    repeat (MUL_LAT) step();

    // flush priority while a divide runs
    cur = md_op(1'b1);
    step();
    cur = '0;
    repeat (3) step();
    cur = lw_use(5'd4, 5'd4);
    cur.start = 1;
    cur.br = 1;
    step();
    chk("fl_flush", s_flush, 1'b1);
    chk("fl_stall", s_stall, 1'b0);
    chk("fl_go", s_go, 1'b0);
    chk("fl_busy", s_busy, 1'b1);
    cur = '0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      done_n += int'(s_done);
    end
    chk("fl_div_done", done_n, 1);

    // reset in divide busy cycle 10
    cur = md_op(1'b1);
    step();
    cur = '0; cur.hilo = 1;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cur = '0;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      busy_n += int'(s_busy);
      done_n += int'(s_done);
    end
    chk("rst_busy", busy_n, 0);
    chk("rst_done", done_n, 0);
    chk("rst_cnt", stall_cnt, 32'd0);

    // stall counter saturation
    dut.stall_cnt = 32'hFFFF_FFFE;
    scnt = 32'hFFFF_FFFE;
    cur = lw_use(5'd8, 5'd8);
    repeat (3) step();
    cur = '0;
    step();
    chk("sat_cnt", stall_cnt, 32'hFFFF_FFFF);

    // random traffic
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      v = '0;
      v.ra0 = 5'($urandom_range(0, 3));
      v.ra1 = 5'($urandom_range(0, 3));
      v.rs_used = 1'($urandom);
      v.rt_used = 1'($urandom);
      v.wen = 1'($urandom);
      v.waddr = 5'($urandom_range(0, 3));
      v.mrd = ($urandom_range(0, 2) == 0);
      v.start = ($urandom_range(0, 3) == 0);
      v.is_div = ($urandom_range(0, 3) == 0);
      v.hilo = ($urandom_range(0, 3) == 0);
      v.br = ($urandom_range(0, 7) == 0);
      cur = v;
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core. It is the stall/flush side of operand bypassing: the forwarding path resolves RAW hazards whose result already exists, and this block handles every hazard that cannot be bypassed.
- Covers three cases: load-use hazards, the multi-cycle HI/LO multiply/divide unit, and taken-branch flushes.
- Drives the IF/ID hold enables, the ID/EX bubble, the ID flush and the mul/div launch strobe. It also keeps a saturating stall-cycle performance counter.

Parameters:
- MUL_LAT, 4: total cycles a MULT/MULTU occupies the mul/div unit (>=2).
- DIV_LAT, 32: total cycles a DIV/DIVU occupies the mul/div unit (>=2).
- CNT_W, 6: width of the latency down-counter; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- rf_raddr0_ID  in  5  rs address of instruction in ID
- rf_raddr1_ID  in  5  rt address of instruction in ID
- rs_used_ID  in  1  ID instruction actually reads rs
- rt_used_ID  in  1  ID instruction actually reads rt
- rf_wen_EX  in  1  EX instruction writes RF
- rf_waddr_EX  in  5  EX destination register
- mem_read_EX  in  1  EX instruction is a load
- md_start_ID  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- md_is_div_ID  in  1  qualifies md_start_ID: 1=divide, 0=multiply
- hilo_access_ID  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO
- branch_taken_EX  in  1  EX resolved a taken branch/jump
- stall_IF  out  1  hold PC
- stall_ID  out  1  hold IF/ID register
- bubble_EX  out  1  insert NOP into ID/EX
- flush_ID  out  1  squash IF/ID contents
- md_go  out  1  one-cycle launch strobe to mul/div unit
- md_busy  out  1  mul/div unit occupied
- md_done  out  1  one-cycle pulse, last busy cycle
- stall_cnt  out  32  saturating count of cycles with stall_ID=1

Behaviour:
- Reset (rst=1 at posedge): FSM=IDLE, counter=0, stall_cnt=0. All combinational outputs evaluate to 0 while in reset state with idle inputs. Reset mid-divide aborts the operation with no md_done.
- Load-use hazard, combinational: lu = mem_read_EX & rf_wen_EX & (rf_waddr_EX!=0) & ((rs_used_ID & rf_raddr0_ID==rf_waddr_EX) | (rt_used_ID & rf_raddr1_ID==rf_waddr_EX)).
- Mul/div hazard, combinational: mdh = md_busy & (md_start_ID | hilo_access_ID).
- Stall: stall = (lu | mdh) & ~branch_taken_EX.
  - stall_IF = stall_ID = bubble_EX = stall.
  - A load-use stall lasts exactly 1 cycle, since the load advances to MEM.
- Flush: flush_ID = branch_taken_EX. Flush has priority over stall. On flush, stall is 0 and the ID instruction is discarded, so no md_go is issued that cycle.
- Launch: md_go = md_start_ID & ~md_busy & ~lu & ~branch_taken_EX.
- FSM states:
  - IDLE: on md_go, load counter with (md_is_div_ID ? DIV_LAT : MUL_LAT) - 1 and go to BUSY.
  - BUSY: md_busy=1; counter decrements each cycle. When counter==1, md_done=1 and the next state is IDLE (counter->0).
  - Total busy cycles = LAT - 1 after the md_go cycle. An instruction stalled on mdh sees md_busy=0 on the cycle after md_done and proceeds.
- A new md_start_ID in the cycle after md_done is accepted (back-to-back). It is never accepted while BUSY.
- branch_taken_EX does not abort a BUSY operation; that operation was launched by an older instruction.
- stall_cnt increments on each cycle with stall=1 and saturates at 32'hFFFF_FFFF (no wrap).
- r0 is never a hazard source.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, BUSY=1'b1) and the MUL_LAT/DIV_LAT defaults, so the mul/div datapath uses the same latencies.
- One natural sub-module, md_latency_tracker: the FSM, down-counter, md_busy and md_done. Top level keeps hazard logic, arbitration and stall_cnt.

Test Plan:
1. Load-use: LW $5 in EX (mem_read_EX=1, waddr=5), ID has rs_used, raddr0=5 -> stall_IF=stall_ID=bubble_EX=1 for exactly 1 cycle; stall_cnt 0->1. Same with waddr=0 -> no stall.
2. Divide with DIV_LAT=32: md_start_ID=1, md_is_div_ID=1 in idle -> md_go=1 for 1 cycle, md_busy=1 for 31 cycles, md_done on the 31st. MFLO in ID during busy -> stall until the cycle after md_done, then stall=0.
3. Back-to-back: MULT (MUL_LAT=4) then MULT -> second held 3 cycles; md_go on the cycle after md_done; md_busy continuous except no gap violation.
4. Flush priority: branch_taken_EX=1 with concurrent lu=1 and md_start_ID=1 -> flush_ID=1, stall=0, md_go=0. BUSY operation already running continues to md_done.
5. Reset mid-divide: rst=1 at busy cycle 10 -> next cycle md_busy=0, md_done never pulses, stall_cnt=0.
6. Saturation: preload/force stall_cnt=32'hFFFF_FFFE and apply 3 stall cycles -> reads 32'hFFFF_FFFF and holds.
